// File: rtl/bju_bpred_if.sv
// Fetch-lookup and execute-resolve signal bundle for the branch/jump unit
// with its predictor.
interface bju_bpred_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] i_if_pc;
  logic            o_pred_taken;
  logic [XLEN-1:0] o_pred_target;
  logic            i_ex_valid;
  logic            i_stall;
  logic            i_b_inst;
  logic [2:0]      i_funct3;
  logic            i_jal;
  logic            i_jalr;
  logic [XLEN-1:0] i_src1;
  logic [XLEN-1:0] i_src2;
  logic [XLEN-1:0] i_fw_rs1_data;
  logic [XLEN-1:0] i_imm;
  logic [XLEN-1:0] i_pc;
  logic            i_ex_pred_taken;
  logic [XLEN-1:0] i_ex_pred_target;
  logic            o_actual_taken;
  logic            o_redirect;
  logic [XLEN-1:0] o_redirect_addr;
  logic [31:0]     o_branch_cnt;
  logic [31:0]     o_mispred_cnt;

  modport master (
    output i_if_pc, i_ex_valid, i_stall, i_b_inst, i_funct3, i_jal, i_jalr,
           i_src1, i_src2, i_fw_rs1_data, i_imm, i_pc, i_ex_pred_taken,
           i_ex_pred_target,
    input  o_pred_taken, o_pred_target, o_actual_taken, o_redirect,
           o_redirect_addr, o_branch_cnt, o_mispred_cnt
  );

  modport slave (
    input  i_if_pc, i_ex_valid, i_stall, i_b_inst, i_funct3, i_jal, i_jalr,
           i_src1, i_src2, i_fw_rs1_data, i_imm, i_pc, i_ex_pred_taken,
           i_ex_pred_target,
    output o_pred_taken, o_pred_target, o_actual_taken, o_redirect,
           o_redirect_addr, o_branch_cnt, o_mispred_cnt
  );
endinterface

// File: rtl/bju_bpred.sv
// Branch/jump resolution in EX plus a BHT/BTB fetch predictor with
// misprediction redirect and performance counters.
module bju_bpred #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned BTB_ENTRIES = 16,
  parameter logic [1:0]  CNT_INIT    = 2'b01
) (
  input logic       i_clk,
  input logic       i_rst,
  bju_bpred_if.slave bus
);
  localparam int unsigned BHT_IW = $clog2(BHT_ENTRIES);
  localparam int unsigned BTB_IW = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W  = XLEN - 2 - BTB_IW;

  logic [1:0]             bht        [BHT_ENTRIES];
  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [BTB_ENTRIES-1:0] btb_jal;
  logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
  logic [XLEN-1:0]        btb_target [BTB_ENTRIES];
  logic [31:0]            branch_cnt;
  logic [31:0]            mispred_cnt;

  logic [BHT_IW-1:0] lk_bht_idx;
  logic [BTB_IW-1:0] lk_btb_idx;
  logic              lk_hit;
  logic              pred_taken;

  // Fetch-side lookup reads stored state only, so a same-cycle update is not seen
  always_comb begin
    lk_bht_idx = bus.i_if_pc[2 +: BHT_IW];
    lk_btb_idx = bus.i_if_pc[2 +: BTB_IW];
    lk_hit     = btb_valid[lk_btb_idx] &&
                 (btb_tag[lk_btb_idx] == bus.i_if_pc[XLEN-1 -: TAG_W]);
    pred_taken = lk_hit && (btb_jal[lk_btb_idx] || bht[lk_bht_idx][1]);
    bus.o_pred_taken  = pred_taken;
    bus.o_pred_target = pred_taken ? btb_target[lk_btb_idx] : '0;
  end

  logic              legal_br;
  logic              br_cond;
  logic              is_jal;
  logic              is_jalr;
  logic              is_br;
  logic              is_ctrl;
  logic              taken;
  logic [XLEN-1:0]   target;
  logic [XLEN-1:0]   fall_through;
  logic              mispred;
  logic              upd;
  logic              redirect;
  logic [BHT_IW-1:0] ex_bht_idx;
  logic [BTB_IW-1:0] ex_btb_idx;
  logic [TAG_W-1:0]  ex_tag;
  logic              ex_hit;

  always_comb begin
    legal_br = 1'b0;
    br_cond  = 1'b0;
    case (bus.i_funct3)
      3'b000: begin legal_br = 1'b1; br_cond = (bus.i_src1 == bus.i_src2); end
      3'b001: begin legal_br = 1'b1; br_cond = (bus.i_src1 != bus.i_src2); end
      3'b100: begin legal_br = 1'b1; br_cond = ($signed(bus.i_src1) <  $signed(bus.i_src2)); end
      3'b101: begin legal_br = 1'b1; br_cond = ($signed(bus.i_src1) >= $signed(bus.i_src2)); end
      3'b110: begin legal_br = 1'b1; br_cond = (bus.i_src1 <  bus.i_src2); end
      3'b111: begin legal_br = 1'b1; br_cond = (bus.i_src1 >= bus.i_src2); end
      default: begin legal_br = 1'b0; br_cond = 1'b0; end
    endcase

    // JAL wins over JALR, which wins over a B-type decode
    is_jal  = bus.i_jal;
    is_jalr = !bus.i_jal && bus.i_jalr;
    is_br   = !bus.i_jal && !bus.i_jalr && bus.i_b_inst && legal_br;
    is_ctrl = is_jal || is_jalr || is_br;

    target       = is_jalr ? ((bus.i_fw_rs1_data + bus.i_imm) & ~XLEN'(1))
                           : (bus.i_pc + bus.i_imm);
    taken        = is_jal || is_jalr || (is_br && br_cond);
    fall_through = bus.i_pc + XLEN'(4);

    mispred  = is_ctrl && ((taken != bus.i_ex_pred_taken) ||
                           (taken && (target != bus.i_ex_pred_target)));
    upd      = bus.i_ex_valid && !bus.i_stall && is_ctrl;
    redirect = bus.i_ex_valid && !bus.i_stall && mispred;

    ex_bht_idx = bus.i_pc[2 +: BHT_IW];
    ex_btb_idx = bus.i_pc[2 +: BTB_IW];
    ex_tag     = bus.i_pc[XLEN-1 -: TAG_W];
    ex_hit     = btb_valid[ex_btb_idx] && (btb_tag[ex_btb_idx] == ex_tag);

    bus.o_actual_taken  = bus.i_ex_valid && is_ctrl && taken;
    bus.o_redirect      = redirect;
    bus.o_redirect_addr = redirect ? (taken ? target : fall_through) : '0;
    bus.o_branch_cnt    = branch_cnt;
    bus.o_mispred_cnt   = mispred_cnt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht[i] <= CNT_INIT;
      btb_valid   <= '0;
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (upd) begin
      if (is_br) begin
        if (taken && bht[ex_bht_idx] != 2'b11)
          bht[ex_bht_idx] <= bht[ex_bht_idx] + 2'd1;
        else if (!taken && bht[ex_bht_idx] != 2'b00)
          bht[ex_bht_idx] <= bht[ex_bht_idx] - 2'd1;
      end
      if (taken && (is_jal || is_br)) begin
        btb_valid[ex_btb_idx]  <= 1'b1;
        btb_jal[ex_btb_idx]    <= is_jal;
        btb_tag[ex_btb_idx]    <= ex_tag;
        btb_target[ex_btb_idx] <= target;
      end else if (is_jalr && ex_hit) begin
        // A JALR is never allocated, so any hit is an aliasing leftover
        btb_valid[ex_btb_idx] <= 1'b0;
      end
      if (branch_cnt != '1) branch_cnt <= branch_cnt + 32'd1;
      if (mispred && mispred_cnt != '1) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

  logic unused_bits;
  assign unused_bits = ^bus.i_if_pc[1:0];

endmodule

// File: tb/tb_bju_bpred.sv
// Self-checking bench for bju_bpred: directed vector table, hand sequences
// and randomized traffic against an array-based reference predictor.
module tb_bju_bpred;
  localparam int unsigned XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bju_bpred_if #(.XLEN(XLEN)) bus ();
  bju_bpred dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: 64 counters, 16 BTB slots, tag = pc >> 6
  int unsigned m_bht [64];
  bit          m_v   [16];
  bit          m_j   [16];
  int unsigned m_tag [16];
  logic [31:0] m_tgt [16];
  longint      m_bc, m_mc;

  typedef struct {
    logic        b, jal, jalr;
    logic [2:0]  f3;
    logic [31:0] s1, s2, rs1, imm, pc;
    logic        pt;
    logic [31:0] ptgt;
    logic        e_taken, e_red;
    logic [31:0] e_addr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
    for (int i = 0; i < 16; i++) m_v[i] = 0;
    m_bc = 0;
    m_mc = 0;
  endfunction

  function automatic void model_lookup(input logic [31:0] pc, output bit t, output logic [31:0] tg);
    int unsigned bi = (pc / 4) % 64;
    int unsigned ti = (pc / 4) % 16;
    bit hit = m_v[ti] && (m_tag[ti] == pc / 64);
    t  = hit && (m_j[ti] || m_bht[bi] >= 2);
    tg = t ? m_tgt[ti] : 32'h0;
  endfunction

  // kind: 0 none, 1 JAL, 2 JALR, 3 branch
  function automatic void model_resolve(output int kind, output bit taken, output logic [31:0] tgt);
    bit c;
    bit legal = 1;
    case (bus.i_funct3)
      3'd0: c = bus.i_src1 == bus.i_src2;
      3'd1: c = bus.i_src1 != bus.i_src2;
      3'd4: c = $signed(bus.i_src1) <  $signed(bus.i_src2);
      3'd5: c = $signed(bus.i_src1) >= $signed(bus.i_src2);
      3'd6: c = bus.i_src1 <  bus.i_src2;
      3'd7: c = bus.i_src1 >= bus.i_src2;
      default: begin c = 0; legal = 0; end
    endcase
    if (bus.i_jal) begin
      kind = 1; taken = 1; tgt = bus.i_pc + bus.i_imm;
    end else if (bus.i_jalr) begin
      kind = 2; taken = 1; tgt = (bus.i_fw_rs1_data + bus.i_imm) & 32'hFFFF_FFFE;
    end else if (bus.i_b_inst && legal) begin
      kind = 3; taken = c; tgt = bus.i_pc + bus.i_imm;
    end else begin
      kind = 0; taken = 0; tgt = 0;
    end
  endfunction

  function automatic bit model_mispred(input int kind, input bit taken, input logic [31:0] tgt);
    return (kind != 0) && ((taken != bus.i_ex_pred_taken) ||
                           (taken && tgt != bus.i_ex_pred_target));
  endfunction

  // Compare every output against the model, mid-cycle
  task automatic sample();
    bit pt, tk, mp, red;
    logic [31:0] ptg, tg, exp_addr;
    int kind;
    @(negedge clk);
    model_lookup(bus.i_if_pc, pt, ptg);
    model_resolve(kind, tk, tg);
    mp  = model_mispred(kind, tk, tg);
    red = bus.i_ex_valid && !bus.i_stall && mp;
    exp_addr = !red ? 32'h0 : (tk ? tg : bus.i_pc + 32'd4);
    check("pred_taken", 32'(bus.o_pred_taken), 32'(pt));
    check("pred_target", bus.o_pred_target, ptg);
    check("actual_taken", 32'(bus.o_actual_taken), 32'(bus.i_ex_valid && kind != 0 && tk));
    check("redirect", 32'(bus.o_redirect), 32'(red));
    check("redirect_addr", bus.o_redirect_addr, exp_addr);
    check("branch_cnt", bus.o_branch_cnt, 32'(m_bc));
    check("mispred_cnt", bus.o_mispred_cnt, 32'(m_mc));
  endtask

  // Apply the architectural update rules, then clock the DUT
  task automatic commit();
    bit tk;
    logic [31:0] tg;
    int kind;
    int unsigned bi, ti;
    model_resolve(kind, tk, tg);
    bi = (bus.i_pc / 4) % 64;
    ti = (bus.i_pc / 4) % 16;
    if (bus.i_ex_valid && !bus.i_stall && kind != 0) begin
      if (kind == 3) begin
        if (tk && m_bht[bi] < 3) m_bht[bi]++;
        if (!tk && m_bht[bi] > 0) m_bht[bi]--;
      end
      if (tk && kind != 2) begin
        m_v[ti] = 1; m_j[ti] = (kind == 1); m_tag[ti] = bus.i_pc / 64; m_tgt[ti] = tg;
      end else if (kind == 2 && m_v[ti] && m_tag[ti] == bus.i_pc / 64) begin
        m_v[ti] = 0;
      end
      if (m_bc < 64'hFFFF_FFFF) m_bc++;
      if (model_mispred(kind, tk, tg) && m_mc < 64'hFFFF_FFFF) m_mc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic b, jal, jalr, input logic [2:0] f3,
                       input logic [31:0] s1, s2, rs1, imm, pc,
                       input logic pt, input logic [31:0] ptgt);
    bus.i_ex_valid = 1; bus.i_stall = 0;
    bus.i_b_inst = b; bus.i_jal = jal; bus.i_jalr = jalr; bus.i_funct3 = f3;
    bus.i_src1 = s1; bus.i_src2 = s2; bus.i_fw_rs1_data = rs1;
    bus.i_imm = imm; bus.i_pc = pc;
    bus.i_ex_pred_taken = pt; bus.i_ex_pred_target = ptgt;
  endtask

  task automatic idle(input logic [31:0] ifpc);
    bus.i_ex_valid = 0; bus.i_stall = 0; bus.i_if_pc = ifpc;
    bus.i_jal = 0; bus.i_jalr = 0; bus.i_b_inst = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask

  function automatic vec_t mk(input logic b, jal, jalr, input logic [2:0] f3,
                              input logic [31:0] s1, s2, rs1, imm, pc,
                              input logic pt, input logic [31:0] ptgt,
                              input logic et, er, input logic [31:0] ea);
    vec_t v;
    v.b = b; v.jal = jal; v.jalr = jalr; v.f3 = f3; v.s1 = s1; v.s2 = s2;
    v.rs1 = rs1; v.imm = imm; v.pc = pc; v.pt = pt; v.ptgt = ptgt;
    v.e_taken = et; v.e_red = er; v.e_addr = ea;
    return v;
  endfunction

  vec_t tbl [13];
  logic [31:0] saved_bc;

  initial begin
    tbl[0]  = mk(1,0,0,3'd0, 32'd5, 32'd5, 0, 32'h40, 32'h100, 0, 0,            1,1,32'h140);
    tbl[1]  = mk(1,0,0,3'd1, 32'd3, 32'd3, 0, 32'h40, 32'h100, 0, 0,            0,0,32'h0);
    tbl[2]  = mk(1,0,0,3'd4, 32'hFFFF_FFFF, 32'd1, 0, 32'h20, 32'h300, 1, 32'h320, 1,0,32'h0);
    tbl[3]  = mk(1,0,0,3'd6, 32'hFFFF_FFFF, 32'd1, 0, 32'h20, 32'h300, 0, 0,     0,0,32'h0);
    tbl[4]  = mk(1,0,0,3'd5, 32'd1, 32'hFFFF_FFFF, 0, 32'h20, 32'h300, 0, 0,     1,1,32'h320);
    tbl[5]  = mk(1,0,0,3'd7, 32'd1, 32'hFFFF_FFFF, 0, 32'h20, 32'h300, 0, 0,     0,0,32'h0);
    tbl[6]  = mk(1,0,0,3'd2, 32'd7, 32'd7, 0, 32'h40, 32'h000, 1, 32'h40,        0,0,32'h0);
    tbl[7]  = mk(0,1,0,3'd0, 0, 0, 0, 32'hFFFF_FFF8, 32'h200, 1, 32'h1F8,       1,0,32'h0);
    tbl[8]  = mk(0,1,0,3'd0, 0, 0, 0, 32'hFFFF_FFF8, 32'h200, 1, 32'h1FC,       1,1,32'h1F8);
    tbl[9]  = mk(0,0,1,3'd0, 0, 0, 32'h1001, 32'h10, 32'h400, 0, 0,             1,1,32'h1010);
    tbl[10] = mk(1,0,0,3'd0, 32'd1, 32'd2, 0, 32'h0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0,1,32'h0);
    tbl[11] = mk(1,1,0,3'd1, 32'd4, 32'd4, 0, 32'h8, 32'h700, 0, 0,             1,1,32'h708);
    tbl[12] = mk(1,0,1,3'd0, 32'd1, 32'd2, 32'h2003, 32'h0, 32'h800, 1, 32'h2002, 1,0,32'h0);

    idle(32'h100);
    bus.i_funct3 = 0; bus.i_src1 = 0; bus.i_src2 = 0; bus.i_fw_rs1_data = 0;
    bus.i_imm = 0; bus.i_pc = 0; bus.i_ex_pred_taken = 0; bus.i_ex_pred_target = 0;
    do_reset();

    // Post-reset lookup
    sample();
    check("rst_pred_taken", 32'(bus.o_pred_taken), 32'd0);
    check("rst_pred_target", bus.o_pred_target, 32'd0);
    check("rst_branch_cnt", bus.o_branch_cnt, 32'd0);
    commit();

    // BEQ taken, predicted not-taken; then the BTB/BHT predict it
    drive(1,0,0,3'd0, 32'd5, 32'd5, 0, 32'h40, 32'h100, 0, 0);
    bus.i_if_pc = 32'h100;
    sample();
    check("beq_redirect", 32'(bus.o_redirect), 32'd1);
    check("beq_addr", bus.o_redirect_addr, 32'h140);
    check("beq_rbw_pred", 32'(bus.o_pred_taken), 32'd0);
    commit();
    idle(32'h100);
    sample();
    check("beq_learn_taken", 32'(bus.o_pred_taken), 32'd1);
    check("beq_learn_target", bus.o_pred_target, 32'h140);
    commit();

    // Same BEQ not taken, predicted taken
    drive(1,0,0,3'd0, 32'd1, 32'd2, 0, 32'h40, 32'h100, 1, 32'h140);
    sample();
    check("beq_nt_redirect", 32'(bus.o_redirect), 32'd1);
    check("beq_nt_addr", bus.o_redirect_addr, 32'h104);
    commit();
    idle(32'h100);
    sample();
    check("beq_nt_pred", 32'(bus.o_pred_taken), 32'd0);
    check("beq_nt_mispred_cnt", bus.o_mispred_cnt, 32'd2);
    check("beq_nt_branch_cnt", bus.o_branch_cnt, 32'd2);
    commit();

    // JALR never allocates; JAL allocates with is_jal
    drive(0,0,1,3'd0, 0, 0, 32'h1001, 32'h10, 32'h400, 0, 0);
    sample();
    check("jalr_addr", bus.o_redirect_addr, 32'h1010);
    commit();
    drive(0,1,0,3'd0, 0, 0, 0, 32'hFFFF_FFF8, 32'h200, 0, 0);
    sample();
    check("jal_addr", bus.o_redirect_addr, 32'h1F8);
    commit();
    idle(32'h400);
    sample();
    check("jalr_no_alloc", 32'(bus.o_pred_taken), 32'd0);
    commit();
    idle(32'h200);
    sample();
    check("jal_btb_taken", 32'(bus.o_pred_taken), 32'd1);
    check("jal_btb_target", bus.o_pred_target, 32'h1F8);
    commit();

    // JALR aliasing onto the JAL's slot invalidates it
    drive(0,0,1,3'd0, 0, 0, 32'h3000, 32'h0, 32'h200, 0, 0);
    sample();
    commit();
    idle(32'h200);
    sample();
    check("jalr_invalidate", 32'(bus.o_pred_taken), 32'd0);
    commit();

    // Stall holds a mispredicted branch for 3 cycles
    saved_bc = bus.o_branch_cnt;
    drive(1,0,0,3'd1, 32'd1, 32'd2, 0, 32'h10, 32'h500, 0, 0);
    bus.i_stall = 1;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("stall_redirect", 32'(bus.o_redirect), 32'd0);
      check("stall_cnt", bus.o_branch_cnt, saved_bc);
      commit();
    end
    bus.i_stall = 0;
    sample();
    check("unstall_redirect", 32'(bus.o_redirect), 32'd1);
    check("unstall_addr", bus.o_redirect_addr, 32'h510);
    commit();
    idle(32'h500);
    sample();
    check("unstall_cnt", bus.o_branch_cnt, saved_bc + 32'd1);
    commit();

    // Directed vector table
    foreach (tbl[k]) begin
      drive(tbl[k].b, tbl[k].jal, tbl[k].jalr, tbl[k].f3, tbl[k].s1, tbl[k].s2,
            tbl[k].rs1, tbl[k].imm, tbl[k].pc, tbl[k].pt, tbl[k].ptgt);
      bus.i_if_pc = tbl[k].pc;
      sample();
      check($sformatf("vec%0d_taken", k), 32'(bus.o_actual_taken), 32'(tbl[k].e_taken));
      check($sformatf("vec%0d_redirect", k), 32'(bus.o_redirect), 32'(tbl[k].e_red));
      check($sformatf("vec%0d_addr", k), bus.o_redirect_addr, tbl[k].e_addr);
      commit();
    end

    // Reset wins over a same-cycle JAL update
    drive(0,1,0,3'd0, 0, 0, 0, 32'h40, 32'h600, 0, 0);
    do_reset();
    idle(32'h600);
    sample();
    check("midrst_pred", 32'(bus.o_pred_taken), 32'd0);
    check("midrst_branch_cnt", bus.o_branch_cnt, 32'd0);
    check("midrst_mispred_cnt", bus.o_mispred_cnt, 32'd0);
    commit();

    // Randomized traffic against the reference model
    for (int n = 0; n < 2000; n++) begin
      logic [31:0] pc, imm;
      bit mpt;
      logic [31:0] mptg;
      int sel = $urandom_range(0, 9);
      pc  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 2);
      imm = 32'($urandom_range(0, 63) * 4) - 32'd128;
      drive(sel <= 6, sel == 7 || sel == 9, sel == 8 || sel == 9, 3'($urandom_range(0, 7)),
            32'($urandom_range(0, 3)) ^ (($urandom % 2) ? 32'h8000_0000 : 32'h0),
            32'($urandom_range(0, 3)) ^ (($urandom % 2) ? 32'h8000_0000 : 32'h0),
            32'($urandom), imm, pc, 0, 0);
      bus.i_ex_valid = ($urandom % 8) != 0;
      bus.i_stall    = ($urandom % 5) == 0;
      model_lookup(pc, mpt, mptg);
      if ($urandom % 3 != 0) begin
        bus.i_ex_pred_taken = mpt; bus.i_ex_pred_target = mptg;
      end else begin
        bus.i_ex_pred_taken = 1'($urandom);
        bus.i_ex_pred_target = ($urandom % 2) ? pc + imm : 32'($urandom);
      end
      bus.i_if_pc = ($urandom % 3 == 0) ? pc
                  : (($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 2));
      sample();
      commit();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
